// File: rtl/cnn_frame_loader.sv
// Pixel-stream front end for the CNN pipeline: packs one frame into the flat img bus,
// fires a one-cycle start pulse, then holds the frame until the pipeline reports done.
module cnn_frame_loader #(
  parameter int PIXEL_W    = 4,
  parameter int NUM_PIXELS = 784,
  parameter int CNT_W      = 8
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PIXEL_W-1:0]            in_pixel,
  input  logic                          in_last,
  output logic [NUM_PIXELS*PIXEL_W-1:0] img,
  output logic                          start,
  input  logic                          done,
  output logic                          frame_done,
  output logic                          err,
  output logic [CNT_W-1:0]              frame_count
);

  localparam int IMG_W = NUM_PIXELS * PIXEL_W;
  localparam int IDX_W = $clog2(NUM_PIXELS);
  localparam int OFF_W = $clog2(IMG_W);

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] FIRE = 2'd1;
  localparam logic [1:0] BUSY = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IMG_W-1:0] img_q;
  logic             start_q, start_d;
  logic             frame_done_q, frame_done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             hs;
  logic [OFF_W-1:0] off;

  assign in_ready = (state_q == LOAD);
  assign hs       = in_valid & in_ready;
  assign off      = OFF_W'(idx_q) * OFF_W'(PIXEL_W);

  // Framing errors drop the frame but keep the stale image; the next pixel restarts at slot 0.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    start_d      = 1'b0;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    cnt_d        = cnt_q;
    case (state_q)
      LOAD: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (in_last) begin
              state_d = FIRE;
              start_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (in_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      FIRE: state_d = BUSY;
      BUSY: begin
        if (done) begin
          state_d      = LOAD;
          frame_done_d = 1'b1;
          cnt_d        = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      idx_q        <= '0;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      start_q      <= start_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Slots only change on a handshake, so img is frozen outside LOAD.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      img_q <= '0;
    end else if (hs) begin
      img_q[off +: PIXEL_W] <= in_pixel;
    end
  end

  assign img         = img_q;
  assign start       = start_q;
  assign frame_done  = frame_done_q;
  assign err         = err_q;
  assign frame_count = cnt_q;

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Bench for cnn_frame_loader: table of frame scenarios plus hand sequences for reset and
// counter wrap; per-cycle pulse expectations flow through a queue scoreboard.
module tb_cnn_frame_loader;

  localparam int PW  = 4;
  localparam int NP  = 784;
  localparam int CW  = 8;
  localparam int IW  = NP * PW;
  localparam int SNP = 4;

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_FIRE = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;

  localparam logic [2:0] EV_START = 3'b100;
  localparam logic [2:0] EV_ERR   = 3'b010;
  localparam logic [2:0] EV_FDONE = 3'b001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, in_last, start, done, frame_done, err;
  logic [PW-1:0] in_pixel;
  logic [IW-1:0] img;
  logic [CW-1:0] frame_count;

  logic             s_valid, s_ready, s_last, s_start, s_done, s_fdone, s_err;
  logic [PW-1:0]    s_pixel;
  logic [SNP*PW-1:0] s_img;
  logic [CW-1:0]    s_count;

  cnn_frame_loader #(.PIXEL_W(PW), .NUM_PIXELS(NP), .CNT_W(CW)) dut (
    .clock(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_last(in_last), .img(img), .start(start), .done(done),
    .frame_done(frame_done), .err(err), .frame_count(frame_count)
  );

  cnn_frame_loader #(.PIXEL_W(PW), .NUM_PIXELS(SNP), .CNT_W(CW)) u_small (
    .clock(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready),
    .in_pixel(s_pixel), .in_last(s_last), .img(s_img), .start(s_start), .done(s_done),
    .frame_done(s_fdone), .err(s_err), .frame_count(s_count)
  );

  typedef struct {
    int npix;
    int last_at;
    int mode;
    bit gap;
    int dw;
    int dh;
    bit early;
    int exp_start;
    int exp_err;
  } vec_t;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_start = 0, n_err = 0, n_fdone = 0;
  int            s_starts = 0, s_fdones = 0, s_errs = 0;
  logic [1:0]    m_state;
  int            m_idx;
  logic [IW-1:0] m_img;
  logic [CW-1:0] m_cnt;
  logic [2:0]    exp_q[$];
  vec_t          vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] get_slot(input logic [IW-1:0] v, input int k);
    logic [IW-1:0] t;
    t = v >> (k * PW);
    return t[PW-1:0];
  endfunction

  function automatic logic [IW-1:0] put_slot(input logic [IW-1:0] v, input int k,
                                             input logic [PW-1:0] p);
    logic [IW-1:0] mask;
    mask = {{(IW-PW){1'b0}}, {PW{1'b1}}} << (k * PW);
    return (v & ~mask) | ({{(IW-PW){1'b0}}, p} << (k * PW));
  endfunction

  task automatic chk_img(input string name);
    int first;
    n_checks++;
    if (img !== m_img) begin
      first = 0;
      for (int k = NP - 1; k >= 0; k--)
        if (get_slot(img, k) !== get_slot(m_img, k)) first = k;
      n_errors++;
      $display("FAIL %s: slot %0d got 0x%0h, expected 0x%0h at %0t", name, first,
               get_slot(img, first), get_slot(m_img, first), $time);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int mode, input int k);
    if (mode == 0) return PW'(k % 16);
    if (mode == 1) return PW'((k * 5 + 3) % 16);
    return PW'($urandom);
  endfunction

  // One clock of the main DUT: predict from current inputs, then compare after the edge.
  task automatic tick();
    logic [2:0] ev;
    ev = 3'b000;
    case (m_state)
      S_LOAD: begin
        if (in_valid) begin
          m_img = put_slot(m_img, m_idx, in_pixel);
          if (in_last && m_idx == NP - 1) begin
            m_state = S_FIRE;
            m_idx   = 0;
            ev      = EV_START;
          end else if (in_last || m_idx == NP - 1) begin
            m_idx = 0;
            ev    = EV_ERR;
          end else begin
            m_idx++;
          end
        end
      end
      S_FIRE: m_state = S_BUSY;
      S_BUSY: begin
        if (done) begin
          m_state = S_LOAD;
          m_cnt   = m_cnt + CW'(1);
          ev      = EV_FDONE;
        end
      end
      default: m_state = S_LOAD;
    endcase
    exp_q.push_back(ev);
    @(posedge clk);
    #1;
    if (start) n_start++;
    if (err) n_err++;
    if (frame_done) n_fdone++;
    chk("pulses{start,err,frame_done}", 32'({start, err, frame_done}), 32'(exp_q.pop_front()));
    chk("in_ready", 32'(in_ready), 32'(m_state == S_LOAD));
    chk("frame_count", 32'(frame_count), 32'(m_cnt));
    chk_img("img");
  endtask

  task automatic send(input int n, input int last_at, input int mode, input bit gap,
                      input logic d);
    done = d;
    for (int k = 0; k < n; k++) begin
      if (gap && (k % 7) == 3) begin
        in_valid = 1'b0;
        in_pixel = PW'($urandom);
        in_last  = 1'b1;
        tick();
      end
      in_valid = 1'b1;
      in_pixel = pix(mode, k);
      in_last  = (k == last_at);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    in_valid = 1'b0;
    in_last  = 1'b0;
    done     = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    m_state = S_LOAD;
    m_idx   = 0;
    m_img   = '0;
    m_cnt   = '0;
    exp_q.delete();
    chk({tag, " start"}, 32'(start), 32'(0));
    chk({tag, " err"}, 32'(err), 32'(0));
    chk({tag, " frame_done"}, 32'(frame_done), 32'(0));
    chk({tag, " in_ready"}, 32'(in_ready), 32'(1));
    chk({tag, " frame_count"}, 32'(frame_count), 32'(0));
    chk_img({tag, " img"});
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic stick();
    @(posedge clk);
    #1;
    if (s_start) s_starts++;
    if (s_fdone) s_fdones++;
    if (s_err) s_errs++;
  endtask

  initial begin
    logic [IW-1:0] snap;
    int            s0, e0, f0;
    logic [CW-1:0] c0;

    vecs[0] = '{100, 99, 1, 1'b0, 0, 0, 1'b1, 0, 1};
    vecs[1] = '{784, 783, 1, 1'b1, 3, 1, 1'b0, 1, 0};
    vecs[2] = '{784, -1, 2, 1'b0, 0, 0, 1'b0, 0, 1};
    vecs[3] = '{784, 783, 2, 1'b0, 2, 5, 1'b1, 1, 0};

    rst_n = 1'b0; in_valid = 1'b0; in_pixel = '0; in_last = 1'b0; done = 1'b0;
    s_valid = 1'b0; s_pixel = '0; s_last = 1'b0; s_done = 1'b0;
    m_state = S_LOAD; m_idx = 0; m_img = '0; m_cnt = '0;

    #12;
    chk("reset in_ready", 32'(in_ready), 32'(1));
    chk("reset start", 32'(start), 32'(0));
    chk("reset err", 32'(err), 32'(0));
    chk("reset frame_done", 32'(frame_done), 32'(0));
    chk("reset frame_count", 32'(frame_count), 32'(0));
    chk_img("reset img");
    #1;
    rst_n = 1'b1;

    // Full frame k mod 16, then BUSY with in_valid held, then done.
    send(NP, NP - 1, 0, 1'b0, 1'b0);
    chk("first frame start count", 32'(n_start), 32'(1));
    chk("first frame in_ready low", 32'(in_ready), 32'(0));
    chk("img[3:0]", 32'(img[3:0]), 32'(0));
    chk("img[63:60]", 32'(img[63:60]), 32'(15));
    chk("img[3135:3132]", 32'(img[3135:3132]), 32'(15));
    tick();
    snap = img;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      in_pixel = PW'($urandom);
      in_last  = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("busy img held", 32'(img !== snap), 32'(0));
    chk("busy start count", 32'(n_start), 32'(1));
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("done frame_done", 32'(frame_done), 32'(1));
    chk("done frame_count", 32'(frame_count), 32'(1));
    chk("done in_ready", 32'(in_ready), 32'(1));

    // Table of framing scenarios.
    for (int v = 0; v < 4; v++) begin
      s0 = n_start; e0 = n_err; f0 = n_fdone; c0 = frame_count;
      send(vecs[v].npix, vecs[v].last_at, vecs[v].mode, vecs[v].gap, vecs[v].early);
      if (vecs[v].exp_start != 0) begin
        for (int c = 0; c < vecs[v].dw + vecs[v].dh + 2; c++) begin
          done = (c == 0 && vecs[v].early) || (c >= vecs[v].dw && c < vecs[v].dw + vecs[v].dh);
          tick();
        end
      end
      done = 1'b0;
      chk($sformatf("vec%0d start pulses", v), 32'(n_start - s0), 32'(vecs[v].exp_start));
      chk($sformatf("vec%0d err pulses", v), 32'(n_err - e0), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d frame_done pulses", v), 32'(n_fdone - f0), 32'(vecs[v].exp_start));
      chk($sformatf("vec%0d frame_count", v), 32'(frame_count),
          32'(CW'(int'(c0) + vecs[v].exp_start)));
      chk($sformatf("vec%0d in_ready", v), 32'(in_ready), 32'(1));
    end

    // Reset mid-frame, then a clean frame must load from slot 0.
    send(400, -1, 1, 1'b0, 1'b0);
    async_reset("rst_load");
    s0 = n_start;
    send(NP, NP - 1, 1, 1'b0, 1'b0);
    chk("post-reset start", 32'(n_start - s0), 32'(1));
    chk("post-reset slot0", 32'(img[3:0]), 32'(3));
    chk("post-reset slot783", 32'(img[3135:3132]), 32'(14));
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("post-reset frame_count", 32'(frame_count), 32'(1));

    // Reset while BUSY.
    send(NP, NP - 1, 2, 1'b0, 1'b0);
    tick();
    tick();
    async_reset("rst_busy");
    s0 = n_start;
    f0 = n_fdone;
    send(NP, NP - 1, 0, 1'b0, 1'b0);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("after busy reset start", 32'(n_start - s0), 32'(1));
    chk("after busy reset frame_done", 32'(n_fdone - f0), 32'(1));
    chk("after busy reset frame_count", 32'(frame_count), 32'(1));
    chk("scoreboard drained", 32'(exp_q.size()), 32'(0));

    // Counter wrap on a 4-pixel instance.
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < SNP; k++) begin
        s_valid = 1'b1;
        s_pixel = PW'(k + f);
        s_last  = (k == SNP - 1);
        stick();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      stick();
      s_done = 1'b1;
      stick();
      s_done = 1'b0;
      if (f == 0) begin
        chk("small img frame0", 32'(s_img), 32'h3210);
        chk("small count frame0", 32'(s_count), 32'(1));
      end
      if (f == 254) chk("small count 255", 32'(s_count), 32'(255));
    end
    chk("small count wrap", 32'(s_count), 32'(0));
    chk("small starts", 32'(s_starts), 32'(256));
    chk("small frame_dones", 32'(s_fdones), 32'(256));
    chk("small errs", 32'(s_errs), 32'(0));
    chk("small in_ready", 32'(s_ready), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cnn_frame_loader.md
# cnn_frame_loader

Front-end feeder for the CNN `top` pipeline. It accepts a row-major stream of 4-bit pixels over a valid/ready handshake and packs a full 28x28 frame into the flat `img` bus. It then issues a one-cycle `start` pulse and holds the frame stable until the pipeline returns `done`. It is the initiator side of the `start`/`img`/`done` interface that the convolution and dense stages consume.

## Interface
- `PIXEL_W`, 4, bits per pixel.
- `NUM_PIXELS`, 784, pixels per frame (28x28).
- `CNT_W`, 8, width of the completed-frame counter.

- `clock`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_pixel` and `in_last` are valid.
- `in_ready`  out  1  loader can accept a pixel; equals (state == LOAD).
- `in_pixel`  in  PIXEL_W  pixel value, row-major, pixel 0 first.
- `in_last`  in  1  marks the final pixel of the frame.
- `img`  out  NUM_PIXELS*PIXEL_W (3136)  packed frame; pixel k at `img[k*PIXEL_W +: PIXEL_W]`.
- `start`  out  1  one-cycle pulse to the pipeline.
- `done`  in  1  pipeline completion; sampled only in BUSY.
- `frame_done`  out  1  one-cycle pulse when a frame's `done` is observed.
- `err`  out  1  one-cycle pulse when a frame is dropped for framing error.
- `frame_count`  out  CNT_W  completed frames, wraps 255 -> 0.

## Operation
- States: LOAD, FIRE, BUSY. Reset puts the block in LOAD with pixel index `idx` = 0.
- Reset values: `img` = 0, `start` = 0, `frame_done` = 0, `err` = 0, `frame_count` = 0. `in_ready` is 1, since the state is LOAD.
- LOAD: a handshake occurs when `in_valid` & `in_ready` are both high. On each handshake, `in_pixel` is written to slot `idx`.
  - Handshake with `idx` = NUM_PIXELS-1 and `in_last` = 1: frame complete. Go to FIRE and clear `idx`.
  - Handshake with `idx` < NUM_PIXELS-1 and `in_last` = 0: increment `idx`.
  - Handshake with `idx` < NUM_PIXELS-1 and `in_last` = 1: short frame. Pulse `err`, clear `idx`, stay in LOAD. The stale contents of `img` remain until overwritten.
  - Handshake with `idx` = NUM_PIXELS-1 and `in_last` = 0: long frame. Pulse `err`, clear `idx`, stay in LOAD. The block does not fire, and subsequent pixels start a new frame.
- FIRE: `start` = 1 for exactly this cycle. Unconditionally go to BUSY. `done` is ignored in FIRE.
- BUSY: `img` is held constant and `in_ready` = 0.
  - `done` sampled high: pulse `frame_done`, increment `frame_count` (mod 2^CNT_W), and go to LOAD.
  - `done` held high for several cycles: it counts once, because the exit from BUSY happens on the first sample.
- `done` asserted in LOAD or FIRE has no effect.
- `in_valid` while not in LOAD: no handshake and no change of state.
- Asserting reset at any point, including mid-frame or in BUSY, aborts the frame. All outputs return to their reset values immediately, without waiting for a clock edge. The pipeline is not notified.

## Timing
- `img` slot k updates on the edge at which pixel k is handshaken.
- Last pixel handshaken at edge T: `start` is high in cycle T..T+1, and state is BUSY from edge T+1.
- `done` sampled at edge D in BUSY: `frame_done` is high for one cycle after D, `frame_count` is updated after D, and `in_ready` = 1 after D.
- The minimum frame period is NUM_PIXELS + 2 + pipeline latency cycles. There is no overlap of frames.
- `err` is high in the cycle after the offending handshake.
- `start`, `frame_done` and `err` are registered. `in_ready` is decoded from the registered state.

## Test plan
- Reset, then stream pixels 0..783 with `in_pixel` = k mod 16 and `in_last` on pixel 783, with `in_valid` held high. Required: `in_ready` drops after the last pixel and `start` pulses exactly once. Required: `img[3:0]` = 0, `img[63:60]` = 15 and `img[3135:3132]` = 15.
- With the block in BUSY, hold `in_valid` = 1 for 50 cycles, then pulse `done`. Required: `img` does not change, no handshakes occur, `frame_done` pulses once, `frame_count` reaches 1, and `in_ready` returns to 1.
- Short frame, with `in_last` on pixel 99. Required: `err` pulses, `start` stays 0. A following correct 784-pixel frame fires normally.
- Long frame, with no `in_last` on pixel 783. Required: `err` pulses and there is no `start`. The next 784 pixels with correct `in_last` fire `start`.
- Hold `done` high for 5 BUSY cycles, and assert `done` during LOAD and FIRE. Required: `frame_count` increments exactly once per frame, and there is no `frame_done` outside BUSY.
- Assert `rst_n` low at pixel 400 and again in BUSY. Required: outputs return to their reset values asynchronously, and `frame_count` = 0. Required: the next full frame loads from `idx` 0 and fires. Run 256 frames and check that `frame_count` wraps to 0.
